// File: rtl/freq_ctrl_pkg.sv
// Shared constants and state type for the playback-rate controller and the
// sample-rate divider that consumes its count.
package freq_ctrl_pkg;

  // Divider terminal count for 8-bit samples at 44 kHz
  localparam int unsigned DEFAULT_COUNT = 32'd614;
  // Fastest allowed rate; the divider must never see a zero count
  localparam int unsigned MIN_COUNT     = 32'd1;
  // Slowest allowed rate
  localparam int unsigned MAX_COUNT     = 32'd4000;
  // Amount moved per speed-up/down event
  localparam int unsigned STEP          = 32'd1;

  // DEFAULT: running at the reset rate; CUSTOM: user has adjusted the rate
  typedef enum logic {
    DEFAULT = 1'b0,
    CUSTOM  = 1'b1
  } freq_state_t;

endpackage : freq_ctrl_pkg

// File: rtl/freq_step_sat.sv
// Combinational saturating +/-STEP on the divider count.
// up alone decrements (faster), down alone increments (slower); both or
// neither leave the count unchanged. Results are clamped to the legal range.
module freq_step_sat
  import freq_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] cnt,
  input  logic         up,
  input  logic         down,
  output logic [N-1:0] next_cnt
);

  localparam logic [N-1:0] MIN_N  = N'(MIN_COUNT);
  localparam logic [N-1:0] MAX_N  = N'(MAX_COUNT);
  localparam logic [N-1:0] STEP_N = N'(STEP);

  // Select the stepped or held count, saturating at both limits
  always_comb begin
    next_cnt = cnt;
    case ({up, down})
      2'b10: begin
        // Compare before subtracting so the count never wraps through zero
        if (cnt <= MIN_N) begin
          next_cnt = MIN_N;
        end else begin
          next_cnt = cnt - STEP_N;
        end
      end
      2'b01: begin
        if (cnt >= MAX_N) begin
          next_cnt = MAX_N;
        end else begin
          next_cnt = cnt + STEP_N;
        end
      end
      default: begin
        next_cnt = cnt;
      end
    endcase
  end

endmodule : freq_step_sat

// File: rtl/frequency_controller.sv
// Holds the divider terminal count that sets audio playback rate.
// Speed-up/down events step the count within saturating limits; speed-reset
// restores the default rate. freq_count is a register with no combinational
// path from the event inputs.
module frequency_controller
  import freq_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         speed_up_event,
  input  logic         speed_down_event,
  input  logic         speed_reset_event,
  output logic [N-1:0] freq_count
);

  localparam logic [N-1:0] DEFAULT_N = N'(DEFAULT_COUNT);

  freq_state_t   custom_state;
  freq_state_t   next_state_s;
  logic [N-1:0]  cnt;
  logic [N-1:0]  next_cnt_s;
  logic [N-1:0]  stepped_cnt_s;

  freq_step_sat #(
    .N (N)
  ) u_step (
    .cnt      (cnt),
    .up       (speed_up_event),
    .down     (speed_down_event),
    .next_cnt (stepped_cnt_s)
  );

  // Priority mux: speed-reset, then cancel, then single-direction step, else hold
  always_comb begin
    next_state_s = custom_state;
    next_cnt_s   = cnt;
    if (speed_reset_event) begin
      next_state_s = DEFAULT;
      next_cnt_s   = DEFAULT_N;
    end else begin
      case ({speed_up_event, speed_down_event})
        2'b10, 2'b01: begin
          // Any accepted step marks the rate as user-adjusted, even if it
          // lands back on the default count or is held by saturation
          next_state_s = CUSTOM;
          next_cnt_s   = stepped_cnt_s;
        end
        2'b11: begin
          next_state_s = custom_state;
          next_cnt_s   = cnt;
        end
        default: begin
          next_state_s = custom_state;
          next_cnt_s   = cnt;
        end
      endcase
    end
  end

  // State and count registers with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      custom_state <= DEFAULT;
      cnt          <= DEFAULT_N;
    end else begin
      custom_state <= next_state_s;
      cnt          <= next_cnt_s;
    end
  end

  assign freq_count = cnt;

endmodule : frequency_controller

// File: tb/tb_frequency_controller.sv
// Self-checking bench for frequency_controller: a behavioural model in plain
// integer arithmetic checked every cycle, plus hand-computed literal checks.
module tb_frequency_controller;

  logic        clk_in;
  logic        reset;
  logic        speed_up_event;
  logic        speed_down_event;
  logic        speed_reset_event;
  logic [31:0] freq_count;

  int n_checks;
  int n_fails;

  // Behavioural model state
  int model_cnt;
  int model_state;
  bit model_valid;

  frequency_controller #(.N(32)) dut (
    .clk_in            (clk_in),
    .reset             (reset),
    .speed_up_event    (speed_up_event),
    .speed_down_event  (speed_down_event),
    .speed_reset_event (speed_reset_event),
    .freq_count        (freq_count)
  );

  // 50 MHz clock
  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  // Model: apply the rate rules to the inputs sampled at each rising edge
  always @(posedge clk_in) begin
    if (!reset) begin
      model_cnt   = 614;
      model_state = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (speed_reset_event) begin
        model_cnt   = 614;
        model_state = 0;
      end else if (speed_up_event && speed_down_event) begin
        model_cnt = model_cnt;
      end else if (speed_up_event) begin
        model_state = 1;
        model_cnt   = (model_cnt - 1 < 1) ? 1 : model_cnt - 1;
      end else if (speed_down_event) begin
        model_state = 1;
        model_cnt   = (model_cnt + 1 > 4000) ? 4000 : model_cnt + 1;
      end
    end
  end

  // Compare DUT against model on every falling edge once reset has been seen
  always @(negedge clk_in) begin
    if (model_valid) begin
      n_checks++;
      if (int'(freq_count) != model_cnt) begin
        n_fails++;
        $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, freq_count, model_cnt);
      end
      n_checks++;
      if (int'(dut.custom_state) != model_state) begin
        n_fails++;
        $display("FAIL model_state t=%0t got=%0d exp=%0d", $time, dut.custom_state, model_state);
      end
      n_checks++;
      if (freq_count < 32'd1 || freq_count > 32'd4000) begin
        n_fails++;
        $display("FAIL range t=%0t got=%0d exp=1..4000", $time, freq_count);
      end
    end
  end

  // Hold the given inputs for n rising edges, then release them at a falling edge
  task automatic apply(input logic u, input logic d, input logic s, input int n);
    speed_up_event    = u;
    speed_down_event  = d;
    speed_reset_event = s;
    repeat (n) @(negedge clk_in);
    speed_up_event    = 1'b0;
    speed_down_event  = 1'b0;
    speed_reset_event = 1'b0;
  endtask

  // Literal expectation, computed by hand
  task automatic check_lit(input string name, input int exp_cnt, input int exp_state);
    n_checks++;
    if (int'(freq_count) != exp_cnt || int'(dut.custom_state) != exp_state) begin
      n_fails++;
      $display("FAIL %s got cnt=%0d state=%0d exp cnt=%0d state=%0d",
               name, freq_count, dut.custom_state, exp_cnt, exp_state);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    n_checks          = 0;
    n_fails           = 0;
    model_valid       = 1'b0;
    model_cnt         = 0;
    model_state       = 0;
    reset             = 1'b0;
    speed_up_event    = 1'b0;
    speed_down_event  = 1'b0;
    speed_reset_event = 1'b0;

    @(negedge clk_in);
    check_lit("reset", 614, 0);
    reset = 1'b1;
    @(negedge clk_in);
    check_lit("idle_hold", 614, 0);

    apply(1'b1, 1'b0, 1'b0, 1);  check_lit("up1", 613, 1);
    apply(1'b1, 1'b0, 1'b0, 1);  check_lit("up2", 612, 1);
    apply(1'b0, 1'b1, 1'b0, 1);  check_lit("down1", 613, 1);
    apply(1'b0, 1'b0, 1'b1, 1);  check_lit("speed_reset", 614, 0);
    apply(1'b1, 1'b1, 1'b0, 1);  check_lit("cancel_default", 614, 0);
    apply(1'b0, 1'b1, 1'b0, 1);  check_lit("down_custom", 615, 1);
    apply(1'b1, 1'b1, 1'b0, 3);  check_lit("cancel_custom", 615, 1);
    apply(1'b1, 1'b0, 1'b1, 1);  check_lit("up_plus_reset", 614, 0);
    apply(1'b0, 1'b1, 1'b1, 1);  check_lit("down_plus_reset", 614, 0);
    apply(1'b1, 1'b0, 1'b0, 1);
    apply(1'b0, 1'b1, 1'b0, 1);  check_lit("back_to_default_stays_custom", 614, 1);
    apply(1'b0, 1'b0, 1'b1, 1);  check_lit("clear_again", 614, 0);

    apply(1'b1, 1'b0, 1'b0, 620);  check_lit("sat_min", 1, 1);
    apply(1'b0, 1'b1, 1'b0, 1);    check_lit("leave_min", 2, 1);
    apply(1'b0, 1'b1, 1'b0, 4100); check_lit("sat_max", 4000, 1);
    apply(1'b1, 1'b0, 1'b0, 1);    check_lit("leave_max", 3999, 1);
    apply(1'b0, 1'b1, 1'b0, 2);    check_lit("resat_max", 4000, 1);

    // Reset wins over a held event
    speed_down_event = 1'b1;
    reset            = 1'b0;
    @(negedge clk_in);
    check_lit("reset_over_event", 614, 0);
    reset            = 1'b1;
    speed_down_event = 1'b0;
    repeat (2) @(negedge clk_in);
    check_lit("post_reset_hold", 614, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_frequency_controller
